// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles both requester ports, the shared response
// (rdata/err/busy) and the data-memory side of dmem_arbiter.
//   slave  : the arbiter itself
//   master : the two requesters (CPU LSU on port 0, external agent on port 1)
//   mem    : the single-port data memory
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // port 0 request bundle
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [2:0]            funct0;
    logic                  ack0;
    // port 1 request bundle
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic [2:0]            funct1;
    logic                  ack1;
    // shared response
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  busy;
    // data memory side
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_funct;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, funct0,
        input  req1, we1, addr1, wdata1, funct1,
        input  mem_rdata,
        output ack0, ack1, rdata, err, busy,
        output mem_wr_en, mem_addr, mem_wdata, mem_funct
    );

    modport master (
        output req0, we0, addr0, wdata0, funct0,
        output req1, we1, addr1, wdata1, funct1,
        input  ack0, ack1, rdata, err, busy
    );

    modport mem (
        input  mem_wr_en, mem_addr, mem_wdata, mem_funct,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data
// memory. Each transaction occupies IDLE -> ACCESS -> RESP (3 cycles).
// Memory-side signals and the read response are registered; misaligned word
// accesses are flagged and never write memory.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined: fixed priority to port 0 with anti-starvation for port 1
//   defined  : round-robin on a last-grant pointer (reset points at port 1)
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] FUNCT_WORD = 3'b010;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_grant;
    logic                  r_we;
    logic                  r_err_flag;
    logic                  r_mem_wr_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [2:0]            r_mem_funct;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_err;

    logic                  w_arb;
    logic                  w_pick1;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [2:0]            w_funct;
    logic                  w_misaligned;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  r_last_grant;

    // Round robin: favour the port that was not granted last time.
    always_comb begin
        w_pick1 = bus.req1 && (!bus.req0 || !r_last_grant);
    end

    // Last-grant pointer; starts at port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if (w_arb) begin
            r_last_grant <= w_pick1;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    logic [7:0]            r_starve_cnt;

    // Fixed priority to port 0, unless port 1 has lost STARVE_LIMIT times in a row.
    always_comb begin
        w_pick1 = bus.req1 && (!bus.req0 || (r_starve_cnt == STARVE_LIM));
    end

    // Count consecutive lost arbitrations of port 1; clear when it wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 8'd0;
        end else if (w_arb) begin
            if (w_pick1) begin
                r_starve_cnt <= 8'd0;
            end else if (bus.req1 && (r_starve_cnt != 8'hFF)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end
`endif

    // Select the winning request bundle and flag misaligned word accesses.
    always_comb begin
        w_arb   = (r_state == IDLE) && (bus.req0 || bus.req1);
        w_we    = w_pick1 ? bus.we1    : bus.we0;
        w_addr  = w_pick1 ? bus.addr1  : bus.addr0;
        w_wdata = w_pick1 ? bus.wdata1 : bus.wdata0;
        w_funct = w_pick1 ? bus.funct1 : bus.funct0;
        w_misaligned = (w_funct == FUNCT_WORD) && (w_addr[1:0] != 2'b00);
    end

    // Next-state logic: fixed three-cycle sequence once a request is taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.req0 || bus.req1) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latch the winner, drive memory in ACCESS, respond in RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant     <= 1'b0;
            r_we        <= 1'b0;
            r_err_flag  <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_funct <= FUNCT_WORD;
            r_rdata     <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        r_grant     <= w_pick1;
                        r_we        <= w_we;
                        r_err_flag  <= w_misaligned;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_funct <= w_funct;
                        r_mem_wr_en <= w_we && !w_misaligned;
                    end
                end
                ACCESS: begin
                    r_mem_wr_en <= 1'b0;
                    r_rdata     <= (r_we || r_err_flag) ? '0 : bus.mem_rdata;
                    r_ack0      <= !r_grant;
                    r_ack1      <= r_grant;
                    r_err       <= r_err_flag;
                end
                default: begin
                    r_mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.rdata     = r_rdata;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != IDLE);
    assign bus.mem_wr_en = r_mem_wr_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_funct = r_mem_funct;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-port scoreboard for
// dmem_arbiter (default fixed-priority build, STARVE_LIMIT = 8).
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .STARVE_LIMIT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- data memory model (little-endian, 256 bytes) ----------
    logic [7:0] mem [0:255] = '{default: 8'h00};

    always @(posedge clk) begin
        logic [7:0] a;
        a = bus.mem_addr[7:0];
        if (bus.mem_wr_en) begin
            if (bus.mem_funct == 3'b000) begin
                mem[a] <= bus.mem_wdata[7:0];
            end else begin
                mem[a]        <= bus.mem_wdata[7:0];
                mem[a + 8'd1] <= bus.mem_wdata[15:8];
                mem[a + 8'd2] <= bus.mem_wdata[23:16];
                mem[a + 8'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        logic [7:0] ra;
        ra = bus.mem_addr[7:0];
        if (bus.mem_funct == 3'b000) begin
            bus.mem_rdata = {24'h0, mem[ra]};
        end else begin
            bus.mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
        end
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          wr_pulses    = 0;
    logic [31:0] last_wr_addr  = '0;
    logic [2:0]  last_wr_funct = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the expected response whenever the DUT acks a port.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.mem_wr_en) begin
                wr_pulses++;
                last_wr_addr  = bus.mem_addr;
                last_wr_funct = bus.mem_funct;
            end
            if (bus.ack0 || bus.ack1)
                check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0) begin
                if (exp_q0.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL ack0_unexpected: got ack0=1, expected no ack");
                end else begin
                    e = exp_q0.pop_front();
                    check("p0_rdata", bus.rdata, e.rdata);
                    check("p0_err", 32'(bus.err), 32'(e.err));
                end
            end
            if (bus.ack1) begin
                if (exp_q1.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL ack1_unexpected: got ack1=1, expected no ack");
                end else begin
                    e = exp_q1.pop_front();
                    check("p1_rdata", bus.rdata, e.rdata);
                    check("p1_err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    // Issue one request, push its expected response, wait (bounded) for the
    // ack and check the latency in cycles from the drive point.
    task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] funct,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat);
        exp_t e;
        int   lat;
        logic got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (port == 0) begin
            exp_q0.push_back(e);
            bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.funct0 = funct;
            bus.req0 = 1'b1;
        end else begin
            exp_q1.push_back(e);
            bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.funct1 = funct;
            bus.req1 = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if ((port == 0) ? bus.ack0 : bus.ack1) got = 1'b1;
        end
        if (port == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
        check($sformatf("p%0d_latency", port), 32'(lat), 32'(exp_lat));
        $display("[TB] port%0d %s addr=0x%08h funct=%03b -> ack after %0d cycles (expected %0d)",
                 port, we ? "store" : "load ", addr, funct, lat, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.funct0 = 3'b010;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.funct1 = 3'b010;

        // Reset state
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_funct", 32'(bus.mem_funct), 32'd2);
        reset = 1'b1;
        @(negedge clk);

        // Port 0 word store then load
        w0 = wr_pulses;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 2);
        check("store_wr_pulses", 32'(wr_pulses - w0), 32'd1);
        do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);

        // Port 1 word store (port 1 alone wins)
        do_req(1, 1'b1, 32'h20, 32'h12345678, 3'b010, 32'h0, 1'b0, 2);

        // Simultaneous requests: port 0 first, port 1 three cycles later
        fork
            do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);
            do_req(1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 1'b0, 5);
        join

        // Starvation: port 1 loses 8 arbitrations, wins the 9th
        fork
            begin
                for (int i = 0; i < 8; i++)
                    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);
                do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 5);
            end
            do_req(1, 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 1'b0, 26);
        join

        // Counter cleared: next contention again goes to port 0
        fork
            do_req(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 1'b0, 2);
            do_req(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 5);
        join

        // Misaligned word store from port 1
        w0 = wr_pulses;
        do_req(1, 1'b1, 32'h13, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1, 2);
        check("misaligned_wr_pulses", 32'(wr_pulses - w0), 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);

        // Byte store and byte load
        w0 = wr_pulses;
        do_req(0, 1'b1, 32'h11, 32'h000000AB, 3'b000, 32'h0, 1'b0, 2);
        check("byte_wr_pulses", 32'(wr_pulses - w0), 32'd1);
        check("byte_wr_addr", last_wr_addr, 32'h11);
        check("byte_wr_funct", 32'(last_wr_funct), 32'd0);
        do_req(0, 1'b0, 32'h11, 32'h0, 3'b000, 32'h000000AB, 1'b0, 2);

        // Reset in the middle of a store's ACCESS cycle
        bus.we0 = 1'b1; bus.addr0 = 32'h30; bus.wdata0 = 32'h55; bus.funct0 = 3'b010;
        bus.req0 = 1'b1;
        @(negedge clk);
        check("abort_wr_en_before", 32'(bus.mem_wr_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_wr_en_after", 32'(bus.mem_wr_en), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
        do_req(0, 1'b0, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, 2);

        // Every expected response must have been consumed
        @(negedge clk);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (`clk`, `wr_en`, `wr_addr`, `wr_data`, `funct`, `rd_data_mem`).
- Shares the memory between two requesters:
  - port 0: CPU load/store unit;
  - port 1: external agent, e.g. the bot sensor/UART loader.
- Uses a req/ack handshake, registered memory-side signals and a registered read response.
- Rejects misaligned word accesses before they reach memory.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, byte address width.
- STARVE_LIMIT, 8, number of consecutive lost arbitrations after which port 1 is forced to win (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held until ack0.
- we0  input  1  port 0 write enable (1 = store, 0 = load).
- addr0  input  ADDR_WIDTH  port 0 byte address.
- wdata0  input  DATA_WIDTH  port 0 store data.
- funct0  input  3  port 0 access size (000 byte, 010 word).
- ack0  output  1  port 0 one-cycle completion pulse.
- req1, we1, addr1, wdata1, funct1  input  as port 0  port 1 request bundle.
- ack1  output  1  port 1 one-cycle completion pulse.
- rdata  output  DATA_WIDTH  load data; valid while ack0 or ack1 is high.
- err  output  1  access rejected; valid while ack0 or ack1 is high.
- mem_wr_en  output  1  to data memory wr_en.
- mem_addr  output  ADDR_WIDTH  to data memory wr_addr.
- mem_wdata  output  DATA_WIDTH  to data memory wr_data.
- mem_funct  output  3  to data memory funct.
- mem_rdata  input  DATA_WIDTH  from data memory rd_data_mem (combinational read).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is asynchronous and active-low.
- Reset (`reset` = 0, takes effect immediately, independent of clk):
  - state = IDLE;
  - ack0, ack1, err, mem_wr_en, busy = 0;
  - rdata, mem_addr, mem_wdata = 0; mem_funct = 3'b010;
  - starve_cnt = 0; grant register = 0.
- States: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle occupancy per transaction.
- IDLE:
  - If req0 or req1 is high at a rising edge, pick a winner and latch its we/addr/wdata/funct into the mem_* registers and the grant register; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration (default, fixed priority with anti-starvation):
  - port 0 wins, unless req1 is high and starve_cnt == STARVE_LIMIT, in which case port 1 wins;
  - starve_cnt increments, saturating, on each arbitration where req1 is high and port 1 loses;
  - starve_cnt clears to 0 whenever port 1 wins.
- Misalignment check:
  - funct == 010 with addr[1:0] != 0 is misaligned;
  - a misaligned request still wins arbitration normally, but sets an internal err flag;
  - mem_wr_en is never asserted for it.
- ACCESS (1 cycle):
  - mem_wr_en = latched we AND NOT err flag; the write commits at the rising edge ending ACCESS;
  - at the same edge, rdata <= mem_rdata for a load, or 0 for a store or error.
  - Then go to RESP.
- RESP (1 cycle):
  - ack of the granted port = 1; err = latched err flag; mem_wr_en = 0.
  - Then go to IDLE unconditionally.
  - req seen during RESP is ignored; the requester must drop req at the edge where it samples ack.
- Latency: req sampled at edge T -> ACCESS in cycle T+1 -> ack in cycle T+2. Next grant no earlier than edge T+3.
- Simultaneous req0/req1: exactly one is granted. The loser keeps req high and is served in the next IDLE.
- Input changes on the non-granted port during a transaction have no effect.
- mem_addr, mem_wdata and mem_funct hold their values after RESP until the next grant.
- Reset mid-transaction: the transaction is aborted. mem_wr_en falls immediately, no ack is issued, and the requester must re-request after reset is released.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - round-robin arbitration: a last-grant pointer gives priority to the port not granted last;
  - pointer reset value = port 1, so port 0 wins the first contention;
  - starve_cnt and STARVE_LIMIT are unused.
- Undefined: fixed priority with anti-starvation, as described in Behaviour.

Test Plan:
- Port 0 store: we0=1, addr0=0x10, wdata0=0xDEADBEEF, funct0=010; then a load from the same address -> ack0 two cycles after each req, load rdata=0xDEADBEEF, err=0.
- req0 and req1 both asserted at edge T (loads from 0x10 and 0x20) -> ack0 in cycle T+2; port 1 re-arbitrated at edge T+3 -> ack1 in cycle T+5; never ack0 and ack1 together.
- Starvation, STARVE_LIMIT=8: req0 held high continuously and req1 high -> port 1 granted on the 9th arbitration; starve_cnt returns to 0.
- Misaligned store: we1=1, addr1=0x13, funct1=010 -> mem_wr_en stays 0 throughout; ack1 with err=1 and rdata=0; word at 0x10 unchanged.
- Port 0 byte store: funct0=000, addr0=0x11, wdata0=0xAB -> one-cycle mem_wr_en with mem_addr=0x11 and mem_funct=000; a subsequent byte load from 0x11 returns 0x000000AB.
- reset driven low mid-ACCESS of a store -> mem_wr_en falls immediately, no ack; after release, busy=0 and a new req0 completes normally.
